// File: rtl/demux_pkg.sv
// Shared definitions for the serial receive demultiplexer: default word width,
// channel indices, per-channel FSM states and the parity accumulate helper.
package demux_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } chan_state_e;

    // Running even-parity check: a result of 1 after the whole frame means an error.
    function automatic logic par_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/demux_chan.sv
// One receive channel: LSB-first shift register, bit counter and frame FSM.
// With DEMUX_RX_PARITY_EN defined each frame carries a trailing even-parity bit.
module demux_chan
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic             ready,
    output logic             perr
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(32'd1);
`ifdef DEMUX_RX_PARITY_EN
    localparam chan_state_e    AFTER_DATA = PAR;
`else
    localparam chan_state_e    AFTER_DATA = IDLE;
`endif

    chan_state_e      state_r, state_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic [WIDTH-1:0] shift_r, shift_nx_s;
    logic [WIDTH-1:0] word_r, word_nx_s;
    logic             ready_r, ready_nx_s;
    logic             last_s;
`ifdef DEMUX_RX_PARITY_EN
    logic             par_r, par_nx_s;
    logic             perr_r, perr_nx_s;
`endif

    assign last_s = (cnt_r == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: clear aborts, otherwise advance only on an accepted bit.
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = IDLE;
        end else if (en) begin
            case (state_r)
                IDLE, SHIFT: begin
                    if (last_s) begin
                        state_nx_s = AFTER_DATA;
                    end else begin
                        state_nx_s = SHIFT;
                    end
                end
                PAR:     state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Output/datapath logic: shift, count, and decide word load or parity error.
    always_comb begin
        cnt_nx_s   = cnt_r;
        shift_nx_s = shift_r;
        word_nx_s  = word_r;
        ready_nx_s = 1'b0;
`ifdef DEMUX_RX_PARITY_EN
        par_nx_s   = par_r;
        perr_nx_s  = 1'b0;
`endif
        if (clear) begin
            cnt_nx_s   = '0;
            shift_nx_s = '0;
`ifdef DEMUX_RX_PARITY_EN
            par_nx_s   = 1'b0;
`endif
        end else if (en) begin
            case (state_r)
                IDLE, SHIFT: begin
                    // New bits enter at the MSB so the first bit ends up in bit 0.
                    shift_nx_s            = shift_r >> 1;
                    shift_nx_s[WIDTH-1]   = d;
                    if (last_s) begin
                        cnt_nx_s = '0;
                    end else begin
                        cnt_nx_s = cnt_r + ONE;
                    end
`ifdef DEMUX_RX_PARITY_EN
                    par_nx_s = par_acc(par_r, d);
`else
                    if (last_s) begin
                        word_nx_s  = shift_nx_s;
                        ready_nx_s = 1'b1;
                    end else begin
                        word_nx_s  = word_r;
                    end
`endif
                end
`ifdef DEMUX_RX_PARITY_EN
                PAR: begin
                    cnt_nx_s = '0;
                    par_nx_s = 1'b0;
                    if (par_acc(par_r, d)) begin
                        perr_nx_s = 1'b1;
                    end else begin
                        word_nx_s  = shift_r;
                        ready_nx_s = 1'b1;
                    end
                end
`endif
                default: begin
                    cnt_nx_s = '0;
                end
            endcase
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            shift_r <= '0;
            word_r  <= '0;
            ready_r <= 1'b0;
`ifdef DEMUX_RX_PARITY_EN
            par_r   <= 1'b0;
            perr_r  <= 1'b0;
`endif
        end else begin
            cnt_r   <= cnt_nx_s;
            shift_r <= shift_nx_s;
            word_r  <= word_nx_s;
            ready_r <= ready_nx_s;
`ifdef DEMUX_RX_PARITY_EN
            par_r   <= par_nx_s;
            perr_r  <= perr_nx_s;
`endif
        end
    end

    assign word  = word_r;
    assign ready = ready_r;
`ifdef DEMUX_RX_PARITY_EN
    assign perr  = perr_r;
`else
    assign perr  = 1'b0;
`endif

endmodule

// File: rtl/demux_rx.sv
// Receive-side 2:1 demultiplexer: routes a serial stream into channels A and B.
// Optional even-parity framing is enabled with DEMUX_RX_PARITY_EN.
module demux_rx
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             valid,
    input  logic             select,
    input  logic             clear,
    output logic [WIDTH-1:0] a_word,
    output logic             a_ready,
    output logic [WIDTH-1:0] b_word,
    output logic             b_ready,
    output logic             a_perr,
    output logic             b_perr
);

    logic en_a_s;
    logic en_b_s;

    assign en_a_s = valid & (select == CH_A);
    assign en_b_s = valid & (select == CH_B);

    demux_chan #(.WIDTH(WIDTH)) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_a_s),
        .d     (d),
        .clear (clear),
        .word  (a_word),
        .ready (a_ready),
        .perr  (a_perr)
    );

    demux_chan #(.WIDTH(WIDTH)) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_b_s),
        .d     (d),
        .clear (clear),
        .word  (b_word),
        .ready (b_ready),
        .perr  (b_perr)
    );

endmodule
